// File: rtl/word_to_byte_unpacker_if.sv
// Handshake bundle between a word-wide producer, the unpacker and a byte-wide consumer.
interface word_to_byte_unpacker_if #(
    parameter int WORD_BYTES = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [8*WORD_BYTES-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_data;
    logic                    out_last;
    logic                    busy;

    // Unpacker view
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

    // Environment view: word producer plus byte consumer
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/word_to_byte_unpacker.sv
// Splits one WORD_BYTES-byte word per input handshake into a stream of byte beats,
// MSB-first or LSB-first, with zero-bubble streaming of back-to-back words.
module word_to_byte_unpacker #(
    parameter int WORD_BYTES = 4,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    word_to_byte_unpacker_if.slave    bus
);

    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

    typedef byte   byte_t;
    typedef byte_t word_t [WORD_BYTES];
    typedef enum logic {IDLE, EMIT} state_t;

    if (WORD_BYTES < 1) begin : g_bad_word_bytes
        $error("word_to_byte_unpacker: WORD_BYTES must be >= 1");
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] idx;
    word_t            word_q;
    logic             last_q;
    logic             at_last;
    logic             load;
    logic             beat;

    assign at_last = (cnt == LAST_CNT);
    assign beat    = (state == EMIT) && bus.out_ready;
    assign load    = bus.in_valid && bus.in_ready;
    // Byte 0 of the word is in_data[7:0]; MSB-first walks the array downwards.
    assign idx     = LSB_FIRST ? cnt : (LAST_CNT - cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nx = EMIT;
                    cnt_nx   = '0;
                end
            end
            EMIT: begin
                if (beat) begin
                    if (at_last) begin
                        cnt_nx   = '0;
                        state_nx = load ? EMIT : IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE) || (bus.out_ready && at_last);
        bus.out_valid = (state == EMIT);
        bus.busy      = (state == EMIT);
        bus.out_last  = (state == EMIT) && last_q && at_last;
        bus.out_data  = 8'h00;
        if (state == EMIT) begin
            bus.out_data = word_q[idx];
        end
    end

    // Word storage carries no reset; out_data is gated to zero outside EMIT.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                word_q[i] <= byte_t'(bus.in_data[8*i +: 8]);
            end
            last_q <= bus.in_last;
        end
    end

    a_byte_width: assert property (@(posedge clk) $bits(byte_t) == 8);
    a_word_width: assert property (@(posedge clk) $bits(word_t) == 8 * WORD_BYTES);

endmodule
